// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
// Shared definitions for the sync_fifo family:
//   clog2   - ceiling log2, used for pointer/count widths
//   is_pow2 - true when a depth is a power of two and at least 2
//   MODE_STD / MODE_FWFT - read-mode selector values for the FWFT parameter
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

    localparam int MODE_STD  = 0;
    localparam int MODE_FWFT = 1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value >= 2) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// -----------------------------------------------------------------------------
// sync_fifo_mem
// DEPTH x DATA_WIDTH storage array for sync_fifo. No full/empty gating is
// done here; the caller decides when a write is legal.
// Ports:
//   clk   - clock, writes on posedge
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - read data, asynchronous (combinational) from raddr
// -----------------------------------------------------------------------------
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int PTR_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [PTR_WIDTH-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [PTR_WIDTH-1:0]  raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    generate
        if (PTR_WIDTH != clog2(DEPTH)) begin : g_bad_addr
            $error("sync_fifo_mem: PTR_WIDTH must equal clog2(DEPTH)");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and synchronous flush. Read mode is either
// registered (FWFT=0, one-cycle latency) or first-word-fall-through (FWFT=1).
// Ports:
//   clk, rst      - clock and synchronous active-high reset
//   clr           - synchronous flush (keeps overflow/underflow)
//   w_en, data_in - write request and data
//   r_en          - read request / pop
//   data_out, data_valid - read data and its qualifier
//   full, empty, almost_full, almost_empty, count - occupancy status
//   overflow, underflow  - sticky error flags, cleared only by rst
// -----------------------------------------------------------------------------
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int PTR_WIDTH  = 3,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 1,
    parameter int FWFT       = MODE_STD
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  r_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [PTR_WIDTH:0]    count,
    output logic                  overflow,
    output logic                  underflow
);

    generate
        if (!is_pow2(DEPTH)) begin : g_bad_depth
            $error("sync_fifo: DEPTH must be a power of two >= 2");
        end
        if (PTR_WIDTH != clog2(DEPTH)) begin : g_bad_ptr
            $error("sync_fifo: PTR_WIDTH must equal clog2(DEPTH)");
        end
        if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
            $error("sync_fifo: AF_THRESH out of range 1..DEPTH");
        end
        if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
            $error("sync_fifo: AE_THRESH out of range 0..DEPTH-1");
        end
        if (FWFT != MODE_STD && FWFT != MODE_FWFT) begin : g_bad_mode
            $error("sync_fifo: FWFT must be 0 or 1");
        end
    endgenerate

    localparam logic [PTR_WIDTH:0] PTR_ONE   = (PTR_WIDTH+1)'(1);
    localparam logic [PTR_WIDTH:0] DEPTH_LVL = (PTR_WIDTH+1)'(DEPTH);
    localparam logic [PTR_WIDTH:0] AF_LVL    = (PTR_WIDTH+1)'(AF_THRESH);
    localparam logic [PTR_WIDTH:0] AE_LVL    = (PTR_WIDTH+1)'(AE_THRESH);

    // Pointers carry one extra wrap bit; only the low bits address memory.
    logic [PTR_WIDTH:0] wptr_q, wptr_d;
    logic [PTR_WIDTH:0] rptr_q, rptr_d;
    logic [PTR_WIDTH:0] count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;

    logic                  full_w, empty_w;
    logic                  rd_acc, wr_acc;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;

    assign full_w  = (count_q == DEPTH_LVL);
    assign empty_w = (count_q == '0);

    // A flush cycle ignores both requests. Writing while full is legal only
    // when a read frees a slot in the same cycle.
    assign rd_acc = r_en & !empty_w & !clr;
    assign wr_acc = w_en & (!full_w | rd_acc) & !clr;
    assign mem_we = wr_acc & !rst;

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clr) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (wr_acc) begin
                wptr_d = wptr_q + PTR_ONE;
            end
            if (rd_acc) begin
                rptr_d = rptr_q + PTR_ONE;
            end
            count_d = count_q + {{PTR_WIDTH{1'b0}}, wr_acc}
                              - {{PTR_WIDTH{1'b0}}, rd_acc};
            if (w_en && !wr_acc) begin
                overflow_d = 1'b1;
            end
            if (r_en && empty_w) begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .PTR_WIDTH  (PTR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wptr_q[PTR_WIDTH-1:0]),
        .wdata (data_in),
        .raddr (rptr_q[PTR_WIDTH-1:0]),
        .rdata (mem_rdata)
    );

    generate
        if (FWFT == MODE_FWFT) begin : g_fwft
            // Head word is presented directly; r_en acknowledges it.
            assign data_out   = mem_rdata;
            assign data_valid = !empty_w;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
            logic                  data_valid_q, data_valid_d;

            always_comb begin
                data_out_d   = data_out_q;
                data_valid_d = rd_acc;
                if (clr) begin
                    data_out_d = '0;
                end else if (rd_acc) begin
                    data_out_d = mem_rdata;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    data_out_q   <= '0;
                    data_valid_q <= 1'b0;
                end else begin
                    data_out_q   <= data_out_d;
                    data_valid_q <= data_valid_d;
                end
            end

            assign data_out   = data_out_q;
            assign data_valid = data_valid_q;
        end
    endgenerate

    assign full         = full_w;
    assign empty        = empty_w;
    assign almost_full  = (count_q >= AF_LVL);
    assign almost_empty = (count_q <= AE_LVL);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo
// Drives one standard-read and one FWFT instance from shared inputs. A table
// of per-cycle vectors carries the expected count, sticky flags and
// data_valid; a queue model of the FIFO contents feeds a scoreboard of
// expected read data. A short hand-written sequence covers FWFT fall-through.
// -----------------------------------------------------------------------------
module tb_sync_fifo;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst, clr, w_en, r_en;
    logic [DW-1:0] data_in;

    logic [DW-1:0] s_data_out, f_data_out;
    logic          s_valid, f_valid;
    logic          s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
    logic          f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
    logic [3:0]    s_count, f_count;

    always #5 clk = ~clk;

    sync_fifo #(.FWFT(0)) u_std (
        .clk(clk), .rst(rst), .clr(clr), .w_en(w_en), .data_in(data_in),
        .r_en(r_en), .data_out(s_data_out), .data_valid(s_valid),
        .full(s_full), .empty(s_empty), .almost_full(s_af),
        .almost_empty(s_ae), .count(s_count), .overflow(s_ovf),
        .underflow(s_udf)
    );

    sync_fifo #(.FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .clr(clr), .w_en(w_en), .data_in(data_in),
        .r_en(r_en), .data_out(f_data_out), .data_valid(f_valid),
        .full(f_full), .empty(f_empty), .almost_full(f_af),
        .almost_empty(f_ae), .count(f_count), .overflow(f_ovf),
        .underflow(f_udf)
    );

    typedef struct {
        logic          rst;
        logic          clr;
        logic          w_en;
        logic          r_en;
        logic [DW-1:0] din;
        int            cnt;
        logic          ovf;
        logic          udf;
        logic          valid;
    } vec_t;

    vec_t          vecs[$];
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] sb_q[$];
    int            checks   = 0;
    int            failures = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic c, input logic w,
                       input logic rd, input logic [DW-1:0] d, input int n,
                       input logic o, input logic u, input logic v);
        vec_t t;
        t.rst = r; t.clr = c; t.w_en = w; t.r_en = rd; t.din = d;
        t.cnt = n; t.ovf = o; t.udf = u; t.valid = v;
        vecs.push_back(t);
    endtask

    task automatic idle();
        rst = 0; clr = 0; w_en = 0; r_en = 0; data_in = '0;
    endtask

    // Apply one vector, advance the model, compare after the edge.
    task automatic apply(input int idx, input vec_t t);
        logic       rd, wr;
        logic [3:0] ec;
        logic [3:0] flags_exp;
        logic [7:0] got;
        rst = t.rst; clr = t.clr; w_en = t.w_en; r_en = t.r_en; data_in = t.din;
        rd = 0; wr = 0;
        if (t.rst || t.clr) begin
            model_q.delete();
        end else begin
            rd = t.r_en && (model_q.size() > 0);
            wr = t.w_en && ((model_q.size() < 8) || rd);
            if (rd) sb_q.push_back(model_q.pop_front());
            if (wr) model_q.push_back(t.din);
        end
        @(posedge clk);
        #1;
        ec = 4'(t.cnt);
        flags_exp = {ec == 4'd8, ec == 4'd0, ec >= 4'd6, ec <= 4'd1};
        chk($sformatf("v%0d count", idx), 32'(s_count), 32'(ec));
        chk($sformatf("v%0d flags{full,empty,af,ae}", idx),
            32'({s_full, s_empty, s_af, s_ae}), 32'(flags_exp));
        chk($sformatf("v%0d err{ovf,udf}", idx),
            32'({s_ovf, s_udf}), 32'({t.ovf, t.udf}));
        chk($sformatf("v%0d data_valid", idx), 32'(s_valid), 32'(t.valid));
        if (s_valid) begin
            if (sb_q.size() == 0) begin
                chk($sformatf("v%0d unexpected read", idx), 32'(s_data_out), 32'hFFFF_FFFF);
            end else begin
                got = sb_q.pop_front();
                chk($sformatf("v%0d data_out", idx), 32'(s_data_out), 32'(got));
            end
        end
        // The FWFT twin tracks the same occupancy and presents the head word.
        chk($sformatf("v%0d fwft valid", idx), 32'(f_valid), 32'(ec != 0));
        if (ec != 0 && model_q.size() > 0) begin
            got = model_q[0];
            chk($sformatf("v%0d fwft head", idx), 32'(f_data_out), 32'(got));
        end
        idle();
    endtask

    initial begin
        idle();
        rst = 1;
        // ---- Test 1: fill with 0x11..0x88 then drain --------------------------
        add(1,0,0,0,8'h00, 0, 0,0, 0);
        for (int i = 0; i < 8; i++) add(0,0,1,0, 8'(8'h11*(i+1)), i+1, 0,0, 0);
        for (int i = 0; i < 8; i++) add(0,0,0,1, 8'h00, 7-i, 0,0, 1);
        // ---- Test 2: full, simultaneous read/write wraps pointers -------------
        for (int i = 0; i < 8; i++) add(0,0,1,0, 8'(8'h11*(i+1)), i+1, 0,0, 0);
        for (int i = 0; i < 4; i++) add(0,0,1,1, 8'(8'hA0+i), 8, 0,0, 1);
        for (int i = 0; i < 8; i++) add(0,0,0,1, 8'h00, 7-i, 0,0, 1);
        // ---- Test 3: underflow, overflow, flags survive clr ---------------
        add(0,0,0,1, 8'h00, 0, 0,1, 0);
        for (int i = 0; i < 8; i++) add(0,0,1,0, 8'(8'hB0+i), i+1, 0,1, 0);
        add(0,0,1,0, 8'hEE, 8, 1,1, 0);
        add(0,1,0,0, 8'h00, 0, 1,1, 0);
        add(0,0,0,1, 8'h00, 0, 1,1, 0);
        // ---- Test 4: empty with simultaneous w_en/r_en ------------------------
        add(1,0,0,0, 8'h00, 0, 0,0, 0);
        add(0,0,1,1, 8'h5A, 1, 0,1, 0);
        add(0,0,0,1, 8'h00, 0, 0,1, 1);
        // ---- Test 6: clr with w_en, then rst mid-operation --------------------
        add(1,0,0,0, 8'h00, 0, 0,0, 0);
        add(0,0,0,1, 8'h00, 0, 0,1, 0);
        for (int i = 0; i < 3; i++) add(0,0,1,0, 8'(8'h61+i), i+1, 0,1, 0);
        add(0,1,1,0, 8'h99, 0, 0,1, 0);
        add(0,0,1,0, 8'h77, 1, 0,1, 0);
        add(0,0,0,1, 8'h00, 0, 0,1, 1);
        add(0,0,1,0, 8'hC1, 1, 0,1, 0);
        add(0,0,1,0, 8'hC2, 2, 0,1, 0);
        add(1,0,1,0, 8'hC3, 0, 0,0, 0);
        add(0,0,1,0, 8'hD1, 1, 0,0, 0);
        add(0,0,0,1, 8'h00, 0, 0,0, 1);

        rst = 0;
        foreach (vecs[i]) apply(i, vecs[i]);
        chk("scoreboard drained", 32'(sb_q.size()), 32'd0);

        // ---- Test 5: FWFT fall-through (hand-written) -------------------------
        rst = 1;
        @(posedge clk); #1;
        idle();
        chk("fwft reset valid", 32'(f_valid), 32'd0);
        chk("fwft reset count", 32'(f_count), 32'd0);
        chk("fwft reset flags{full,empty,af,ae,ovf,udf}",
            32'({f_full, f_empty, f_af, f_ae, f_ovf, f_udf}), 32'b010100);
        w_en = 1; data_in = 8'h3C;
        @(posedge clk); #1;
        idle();
        chk("fwft valid after write", 32'(f_valid), 32'd1);
        chk("fwft data after write", 32'(f_data_out), 32'h3C);
        chk("std valid without r_en", 32'(s_valid), 32'd0);
        @(posedge clk); #1;
        chk("fwft data held", 32'(f_data_out), 32'h3C);
        r_en = 1;
        @(posedge clk); #1;
        idle();
        chk("fwft valid after pop", 32'(f_valid), 32'd0);
        chk("fwft empty after pop", 32'(f_empty), 32'd1);
        chk("std read of 0x3C", 32'({s_valid, s_data_out}), 32'h13C);
        @(posedge clk); #1;
        chk("std valid one cycle", 32'(s_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
